load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Sits between the single-cycle datapath and the data memory (word-addressed, combinational read, write on posedge).
//  Adds byte/halfword access: lb, lbu, lh, lhu, sb, sh, plus lw/sw pass-through.
//  Detects misaligned accesses and records the first faulting address.
//  Sub-word stores run as a 2-cycle read-modify-write (RMW), with a stall to the core.
//  Byte order is little-endian: byte lane n = addr[1:0]==n = data bits [8n+7:8n].
// PARAMETERS
//  ADDR_W   16  byte-address width on the core and memory sides
//  DATA_W   32  data width; only 32 is supported (elaboration error otherwise)
// PORTS
//  clock          in   1       system clock; all state updates on posedge
//  rst            in   1       asynchronous, active-low reset
//  cpu_memRead    in   1       core load request (single-cycle, level)
//  cpu_memWrite   in   1       core store request (single-cycle, level)
//  cpu_size       in   2       00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  cpu_unsigned   in   1       loads: 1 zero-extend, 0 sign-extend
//  cpu_addr       in   ADDR_W  byte address
//  cpu_wdata      in   32      store data, right-justified
//  cpu_rdata      out  32      extended load data
//  stall          out  1       core must hold PC and all cpu_* inputs while 1
//  misaligned     out  1       current request misaligned (combinational)
//  fault_valid    out  1       sticky: a misaligned access occurred
//  fault_addr     out  ADDR_W  address of the first misaligned access
//  fault_clear    in   1       clears fault_valid and fault_addr on the next posedge
//  mem_addr       out  ADDR_W  to memory addr
//  mem_writeData  out  32      to memory writeData
//  mem_memWrite   out  1       to memory memWrite
//  mem_memRead    out  1       to memory memRead
//  mem_readData   in   32      from memory readData
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, merge_q=0, addr_q=0, fault_valid=0, fault_addr=0.
//   While in reset, all mem_* outputs and stall are 0.
//  Alignment: half needs addr[0]=0; word needs addr[1:0]=0; byte is always aligned.
//   On a misaligned request: misaligned=1 and no memory strobe is driven.
//   The store is dropped and cpu_rdata=0.
//   If fault_valid=0, capture fault_valid=1 and fault_addr=cpu_addr at posedge.
//   fault_clear has priority over a new capture in the same cycle.
//  Write priority: if memRead and memWrite are both 1, the access is treated as a store;
//   the read is ignored and cpu_rdata=0.
//  FSM states: IDLE, RMW_WR.
//  IDLE, load (aligned):
//   - mem_memRead=1, mem_addr=cpu_addr, stall=0.
//   - cpu_rdata = selected lane of mem_readData, extended per cpu_unsigned.
//   - Latency 0; stays in IDLE.
//  IDLE, word store (aligned):
//   - mem_memWrite=1, mem_writeData=cpu_wdata, stall=0.
//   - Memory updates at this posedge; stays in IDLE.
//  IDLE, byte/half store (aligned):
//   - mem_memRead=1, mem_memWrite=0, stall=1.
//   - merge_q <= mem_readData with the addressed lane(s) replaced by cpu_wdata[7:0] or [15:0].
//   - addr_q <= cpu_addr; next state RMW_WR.
//  RMW_WR:
//   - mem_memWrite=1, mem_addr=addr_q, mem_writeData=merge_q, stall=0.
//   - Inputs are ignored this cycle (the core still holds the same store); next state IDLE.
//   - The core advances after this edge.
//  No request: all mem_* strobes 0, mem_addr=cpu_addr, cpu_rdata=0.
//  Reset mid-RMW (during RMW_WR): the write is not issued, memory is unchanged, FSM returns to IDLE.
//  Address bits above the memory depth pass through unchanged; the memory wraps by its own indexing.
// STRUCTURE
//  Shared include lsu_defs.vh holds:
//   - SIZE_BYTE/HALF/WORD encodings
//   - FSM state encodings (IDLE=1'b0, RMW_WR=1'b1)
//   - an endianness localparam
//  Sub-module lsu_lane_mux (combinational): lane extract + sign/zero extend, and lane insert for merge.
//  The top level holds the FSM, merge_q/addr_q, and the fault register.
// TESTING  (memory word at 0x10 preloaded 0x11223380)
//  1. lbu @0x13 -> cpu_rdata=0x00000011, stall=0.
//     lb @0x10 -> 0xFFFFFF80. lhu @0x12 -> 0x00001122.
//  2. sb 0x000000AB @0x11:
//     cyc1 stall=1, mem_memRead=1; cyc2 mem_memWrite=1, writeData=0x1122AB80.
//     Then lw @0x10 -> 0x1122AB80.
//  3. sh 0x0000BEEF @0x12 -> written word 0xBEEF3380. Exactly 2 cycles; stall high only in cycle 1.
//  4. lw @0x0A -> misaligned=1, no mem strobes, fault_valid=1, fault_addr=0x000A.
//     sh @0x13 next -> fault_addr stays 0x000A.
//     fault_clear=1 -> fault_valid=0, fault_addr=0 next cycle.
//  5. sb @0x10, then rst=0 during RMW_WR -> word stays 0x11223380; stall=0, state IDLE after release.
//  6. sw 0xDEADBEEF @0x20, then lw @0x20 on the next cycle -> 0xDEADBEEF. No stall on either cycle.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit:
// access sizes, FSM states and lane ordering.
package load_store_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] RMW_WR = 1'b1;

    localparam bit LITTLE_ENDIAN = 1'b1;

    // Halfwords need even addresses; words (and the reserved size) need 4-byte alignment.
    function automatic logic misaligned_access(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic is_half;
        logic is_word;
        is_half = (size == SIZE_HALF);
        is_word = size[1];
        return (is_half & lo[0]) | (is_word & (lo != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_lane_mux.sv
// Lane extract with sign/zero extension for loads,
// and lane insert that builds the merged word for sub-word stores.
module load_store_unit_lane_mux
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [1:0]  eff_lane;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        is_byte;
    logic        is_half;

    assign eff_lane = LITTLE_ENDIAN ? lane : ~lane;
    assign is_byte  = (size == SIZE_BYTE);
    assign is_half  = (size == SIZE_HALF);

    // Pick the addressed byte and halfword out of the memory word.
    always_comb begin
        byte_sel = rdata[7:0];
        half_sel = eff_lane[1] ? rdata[31:16] : rdata[15:0];
        unique case (eff_lane)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
    end

    // Extend the selected lane and splice the store data into the old word.
    always_comb begin
        load_data  = rdata;
        merge_data = wdata;
        unique case (1'b1)
            is_byte: begin
                load_data  = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
                merge_data = rdata;
                unique case (eff_lane)
                    2'd0: merge_data[7:0]   = wdata[7:0];
                    2'd1: merge_data[15:8]  = wdata[7:0];
                    2'd2: merge_data[23:16] = wdata[7:0];
                    2'd3: merge_data[31:24] = wdata[7:0];
                    default: merge_data = rdata;
                endcase
            end
            is_half: begin
                load_data  = {{16{~is_unsigned & half_sel[15]}}, half_sel};
                merge_data = rdata;
                if (eff_lane[1]) begin
                    merge_data[31:16] = wdata[15:0];
                end else begin
                    merge_data[15:0] = wdata[15:0];
                end
            end
            default: begin
                load_data  = rdata;
                merge_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte/halfword load-store adapter between a single-cycle core and
// a word-wide memory; sub-word stores use a two-cycle read-modify-write.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              cpu_memRead,
    input  logic              cpu_memWrite,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_unsigned,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    output logic              misaligned,
    output logic              fault_valid,
    output logic [ADDR_W-1:0] fault_addr,
    input  logic              fault_clear,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_memWrite,
    output logic              mem_memRead,
    input  logic [DATA_W-1:0] mem_readData
);

    if (DATA_W != 32) begin : g_bad_width
        $error("load_store_unit: only DATA_W=32 is supported");
    end

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [31:0]       merge_q;
    logic [ADDR_W-1:0] addr_q;
    logic              fault_valid_q;
    logic [ADDR_W-1:0] fault_addr_q;

    logic        req_any;
    logic        req_wr;
    logic        req_rd;
    logic        in_rmw;
    logic        bad_req;
    logic        ok_req;
    logic        wr_word;
    logic        wr_sub;
    logic        rd_req;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign req_any = cpu_memRead | cpu_memWrite;
    assign req_wr  = cpu_memWrite;
    assign req_rd  = cpu_memRead & ~cpu_memWrite;
    assign in_rmw  = (state_q == RMW_WR);
    assign bad_req = ~in_rmw & req_any
                   & misaligned_access(cpu_size, cpu_addr[1:0]);
    assign ok_req  = ~in_rmw & ~bad_req;
    assign wr_word = ok_req & req_wr & cpu_size[1];
    assign wr_sub  = ok_req & req_wr & ~cpu_size[1];
    assign rd_req  = ok_req & req_rd;

    assign misaligned  = bad_req;
    assign fault_valid = fault_valid_q;
    assign fault_addr  = fault_addr_q;

    load_store_unit_lane_mux u_lane_mux (
        .lane        (cpu_addr[1:0]),
        .size        (cpu_size),
        .is_unsigned (cpu_unsigned),
        .rdata       (mem_readData[31:0]),
        .wdata       (cpu_wdata[31:0]),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    // Steer the memory port and stall; everything is forced quiet while in reset.
    always_comb begin
        state_d       = state_q;
        mem_addr      = cpu_addr;
        mem_writeData = cpu_wdata;
        mem_memRead   = 1'b0;
        mem_memWrite  = 1'b0;
        stall         = 1'b0;
        cpu_rdata     = '0;
        unique case (1'b1)
            in_rmw: begin
                mem_memWrite  = 1'b1;
                mem_addr      = addr_q;
                mem_writeData = merge_q;
                state_d       = IDLE;
            end
            bad_req: begin
                state_d = IDLE;
            end
            wr_word: begin
                mem_memWrite = 1'b1;
            end
            wr_sub: begin
                mem_memRead = 1'b1;
                stall       = 1'b1;
                state_d     = RMW_WR;
            end
            rd_req: begin
                mem_memRead = 1'b1;
                cpu_rdata   = load_data;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!rst) begin
            mem_addr      = '0;
            mem_writeData = '0;
            mem_memRead   = 1'b0;
            mem_memWrite  = 1'b0;
            stall         = 1'b0;
        end
    end

    // FSM state plus the merged word and address held for the write cycle.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            merge_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (wr_sub) begin
                merge_q <= merge_data;
                addr_q  <= cpu_addr;
            end
        end
    end

    // Sticky record of the first misaligned address; a clear wins over a capture.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            fault_valid_q <= 1'b0;
            fault_addr_q  <= '0;
        end else if (fault_clear) begin
            fault_valid_q <= 1'b0;
            fault_addr_q  <= '0;
        end else if (bad_req && !fault_valid_q) begin
            fault_valid_q <= 1'b1;
            fault_addr_q  <= cpu_addr;
        end
    end

endmodule
